// File: rtl/keccak_squeeze_serializer.sv
// Flattens a Keccak state A[x][y][z] into S and streams its first RATE_BITS as OUT_W-bit words.
// Requests a new permutation each time a rate block runs out while more output is owed.
module keccak_squeeze_serializer #(
  parameter int LANE_W    = 64,
  parameter int RATE_BITS = 1088,
  parameter int OUT_W     = 64,
  parameter int LEN_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len_words,
  input  logic             st_valid,
  output logic             st_ready,
  input  logic             state_a [0:4][0:4][0:LANE_W-1],
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_last,
  output logic             perm_req,
  output logic             busy,
  output logic             done
);

  localparam int WPB = RATE_BITS / OUT_W;
  localparam int IW  = (WPB > 1) ? $clog2(WPB) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_ST, EMIT, FIN} state_t;

  state_t           state;
  logic [OUT_W-1:0] blk [WPB];
  logic [IW-1:0]    idx;
  logic [IW-1:0]    idx_nxt;
  logic [LEN_W-1:0] remaining;
  logic [RATE_BITS-1:0] s_rate;

  assign idx_nxt = idx + 1'b1;

  // Only the rate portion of S is ever gathered; capacity lanes are left untouched.
  always_comb begin
    s_rate = '0;
    for (int i = 0; i < RATE_BITS; i++) begin
      s_rate[i] = state_a[(i / LANE_W) % 5][(i / LANE_W) / 5][i % LANE_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      st_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      perm_req  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      idx       <= '0;
      remaining <= '0;
      for (int w = 0; w < WPB; w++) begin
        blk[w] <= '0;
      end
    end else begin
      perm_req <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (len_words != '0) begin
              remaining <= len_words;
              st_ready  <= 1'b1;
              state     <= WAIT_ST;
            end else begin
              done  <= 1'b1;
              state <= FIN;
            end
          end
        end
        WAIT_ST: begin
          if (st_valid) begin
            for (int w = 0; w < WPB; w++) begin
              blk[w] <= s_rate[OUT_W*w +: OUT_W];
            end
            idx       <= '0;
            st_ready  <= 1'b0;
            out_valid <= 1'b1;
            out_data  <= s_rate[OUT_W-1:0];
            out_last  <= (remaining == LEN_W'(1));
            state     <= EMIT;
          end
        end
        EMIT: begin
          if (out_ready) begin
            remaining <= remaining - 1'b1;
            if (remaining == LEN_W'(1)) begin
              idx       <= (idx == IW'(WPB - 1)) ? '0 : idx_nxt;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              done      <= 1'b1;
              state     <= FIN;
            end else if (idx == IW'(WPB - 1)) begin
              // Block exhausted with output still owed: ask the core for the next state.
              idx       <= '0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              perm_req  <= 1'b1;
              st_ready  <= 1'b1;
              state     <= WAIT_ST;
            end else begin
              idx      <= idx_nxt;
              out_data <= blk[idx_nxt];
              out_last <= (remaining == LEN_W'(2));
            end
          end
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keccak_squeeze_serializer.sv
// Scoreboard bench: default-parameter instance (a) plus a 32-bit output instance (b).
module tb_keccak_squeeze_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        start, st_valid, st_ready, out_valid, out_ready, out_last, perm_req, busy, done;
  logic [15:0] len_words;
  logic [63:0] out_data;
  logic        sa [0:4][0:4][0:63];

  logic        b_start, b_st_valid, b_st_ready, b_out_valid, b_out_ready, b_out_last;
  logic        b_perm_req, b_busy, b_done;
  logic [15:0] b_len_words;
  logic [31:0] b_out_data;
  logic        sb [0:4][0:4][0:63];

  keccak_squeeze_serializer dut (
    .clk(clk), .rst(rst), .start(start), .len_words(len_words),
    .st_valid(st_valid), .st_ready(st_ready), .state_a(sa),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .perm_req(perm_req), .busy(busy), .done(done)
  );

  keccak_squeeze_serializer #(.OUT_W(32)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .len_words(b_len_words),
    .st_valid(b_st_valid), .st_ready(b_st_ready), .state_a(sb),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_last(b_out_last),
    .perm_req(b_perm_req), .busy(b_busy), .done(b_done)
  );

  typedef struct packed {
    logic [63:0] d;
    logic        l;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Output monitors: scoreboard pop on transfer, stall stability, perm_req shape.
  int          xa = 0, perm_a = 0, done_a = 0;
  logic        stall_a = 1'b0, pl_a = 1'b0, pp_a = 1'b0, prst_a = 1'b0;
  logic [63:0] pd_a = '0;
  always @(negedge clk) begin
    exp_t e;
    if (stall_a && !prst_a) begin
      chk("a_stall_valid", out_valid, 1);
      chk("a_stall_data", out_data, pd_a);
      chk("a_stall_last", out_last, pl_a);
    end
    stall_a = (out_valid === 1'b1) && !out_ready;
    pd_a = out_data; pl_a = out_last; prst_a = rst;
    if (out_valid === 1'b1 && out_ready) begin
      xa++;
      if (qa.size() == 0) chk("a_extra_word", 1, 0);
      else begin
        e = qa.pop_front();
        chk("a_data", out_data, e.d);
        chk("a_last", out_last, e.l);
      end
    end
    if (perm_req === 1'b1) begin
      perm_a++;
      chk("a_perm_after_17", xa, 17);
      chk("a_perm_one_cycle", pp_a, 0);
    end
    pp_a = (perm_req === 1'b1);
    if (done === 1'b1) done_a++;
  end

  int          xb = 0, done_b = 0;
  logic        stall_b = 1'b0, pl_b = 1'b0, prst_b = 1'b0;
  logic [31:0] pd_b = '0;
  always @(negedge clk) begin
    exp_t e;
    if (stall_b && !prst_b) begin
      chk("b_stall_data", b_out_data, pd_b);
      chk("b_stall_last", b_out_last, pl_b);
    end
    stall_b = (b_out_valid === 1'b1) && !b_out_ready;
    pd_b = b_out_data; pl_b = b_out_last; prst_b = rst;
    if (b_out_valid === 1'b1 && b_out_ready) begin
      xb++;
      if (qb.size() == 0) chk("b_extra_word", 1, 0);
      else begin
        e = qb.pop_front();
        chk("b_data", b_out_data, e.d);
        chk("b_last", b_out_last, e.l);
      end
    end
    if (b_perm_req === 1'b1) chk("b_perm_unexpected", 1, 0);
    if (b_done === 1'b1) done_b++;
  end

  task automatic set_lanes_a(input int base);
    logic [63:0] v;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++) begin
        v = 64'(base + 5*y + x);
        for (int z = 0; z < 64; z++) sa[x][y][z] = v[z];
      end
  endtask

  task automatic set_lane_b(input int x, input int y, input logic [63:0] v);
    for (int z = 0; z < 64; z++) sb[x][y][z] = v[z];
  endtask

  task automatic push_a(input int first, input int n, input logic last_at_end);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.d = 64'(first + k);
      e.l = last_at_end && (k == n - 1);
      qa.push_back(e);
    end
  endtask

  task automatic push_b(input logic [63:0] d, input logic l);
    exp_t e;
    e.d = d; e.l = l;
    qb.push_back(e);
  endtask

  task automatic go_a(input int n);
    @(posedge clk); #1;
    len_words = 16'(n); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic serve_a(input int base);
    int k = 0;
    while (st_ready !== 1'b1 && k < 60) begin @(negedge clk); k++; end
    if (st_ready !== 1'b1) begin chk("a_st_ready_timeout", 0, 1); return; end
    set_lanes_a(base);
    st_valid = 1'b1;
    @(posedge clk); #1;
    st_valid = 1'b0;
    @(negedge clk);
    chk("a_first_word_latency", out_valid, 1);
    chk("a_st_ready_after_accept", st_ready, 0);
    chk("a_busy_active", busy, 1);
  endtask

  task automatic wait_done_a(input int budget, output int c);
    c = 0;
    while (done !== 1'b1 && c < budget) begin @(negedge clk); c++; end
    if (done !== 1'b1) chk("a_done_timeout", 0, 1);
  endtask

  task automatic run_b(input int n);
    int k = 0;
    @(posedge clk); #1;
    b_len_words = 16'(n); b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    while (b_st_ready !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    if (b_st_ready !== 1'b1) chk("b_st_ready_timeout", 0, 1);
    b_st_valid = 1'b1;
    @(posedge clk); #1;
    b_st_valid = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    logic seen;

    // Reset with every input pushing for activity.
    rst = 1'b1; start = 1'b1; len_words = 16'd3; st_valid = 1'b1; out_ready = 1'b1;
    b_start = 1'b1; b_len_words = 16'd3; b_st_valid = 1'b1; b_out_ready = 1'b1;
    set_lanes_a(0);
    for (int x = 0; x < 5; x++) for (int y = 0; y < 5; y++) set_lane_b(x, y, 64'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_st_ready", st_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_perm_req", perm_req, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_b_out_valid", b_out_valid, 0);
    end
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0; st_valid = 1'b0; b_start = 1'b0; b_st_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_out_valid", out_valid, 0);

    // Three words, single block, continuous ready.
    xa = 0; perm_a = 0; done_a = 0;
    push_a(0, 3, 1'b1);
    go_a(3);
    serve_a(0);
    wait_done_a(20, c);
    chk("len3_done_cycle", c, 3);
    @(negedge clk);
    chk("len3_words", xa, 3);
    chk("len3_queue_empty", qa.size(), 0);
    chk("len3_no_perm", perm_a, 0);
    chk("len3_done_pulses", done_a, 1);
    chk("len3_idle", busy, 0);

    // Twenty words across two blocks; second state offered alongside perm_req.
    xa = 0; perm_a = 0; done_a = 0;
    push_a(0, 17, 1'b0);
    push_a(100, 3, 1'b1);
    go_a(20);
    serve_a(0);
    serve_a(100);
    wait_done_a(60, c);
    @(negedge clk);
    chk("len20_words", xa, 20);
    chk("len20_queue_empty", qa.size(), 0);
    chk("len20_perm_count", perm_a, 1);
    chk("len20_done_pulses", done_a, 1);

    // Backpressure with 4-cycle low stretches.
    xa = 0; perm_a = 0; done_a = 0;
    push_a(0, 5, 1'b1);
    go_a(5);
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          @(posedge clk); #1;
          out_ready = (i % 6 < 4) ? 1'b0 : (1'($urandom_range(0, 1)) | (i % 6 == 5));
        end
        out_ready = 1'b1;
      end
      begin
        serve_a(0);
        wait_done_a(200, c);
      end
    join
    @(negedge clk);
    chk("bp_words", xa, 5);
    chk("bp_queue_empty", qa.size(), 0);
    chk("bp_done_pulses", done_a, 1);

    // Zero-length request: straight to done.
    xa = 0; perm_a = 0; done_a = 0; seen = 1'b0;
    go_a(0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      seen = seen | (st_ready === 1'b1) | (out_valid === 1'b1) | (perm_req === 1'b1);
    end
    chk("len0_no_activity", seen, 0);
    chk("len0_done_pulses", done_a, 1);
    chk("len0_idle", busy, 0);

    // 32-bit words: each 64-bit lane splits low half first.
    xb = 0; done_b = 0;
    set_lane_b(0, 0, 64'hAAAABBBB_CCCCDDDD);
    set_lane_b(1, 0, 64'h11112222_33334444);
    push_b(64'hCCCCDDDD, 1'b0);
    push_b(64'hAAAABBBB, 1'b0);
    push_b(64'h33334444, 1'b0);
    push_b(64'h11112222, 1'b1);
    run_b(4);
    c = 0;
    while (b_done !== 1'b1 && c < 30) begin @(negedge clk); c++; end
    if (b_done !== 1'b1) chk("b_done_timeout", 0, 1);
    @(negedge clk);
    chk("b_words", xb, 4);
    chk("b_queue_empty", qb.size(), 0);
    chk("b_done_pulses", done_b, 1);

    // Reset in the middle of emission, then an unsolicited state.
    xb = 0;
    push_b(64'hCCCCDDDD, 1'b0);
    push_b(64'hAAAABBBB, 1'b0);
    run_b(4);
    c = 0;
    while (xb < 2 && c < 30) begin @(negedge clk); #1; c++; end
    if (xb < 2) chk("b_midrst_timeout", xb, 2);
    @(posedge clk); #1;
    rst = 1'b1; b_out_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", b_out_valid, 0);
    chk("midrst_busy", b_busy, 0);
    chk("midrst_st_ready", b_st_ready, 0);
    b_st_valid = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      seen = seen | (b_out_valid === 1'b1) | (b_st_ready === 1'b1) | (b_busy === 1'b1);
    end
    b_st_valid = 1'b0;
    chk("midrst_state_ignored", seen, 0);
    chk("midrst_queue_empty", qb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
